decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/reg_file.sv | 39 +++
 rtl/decode_stage.sv | 118 +++++++++++
 tb/tb_decode_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, opcode encoding and instruction layout for the decode path.
// The instr_t field order fixes the bit positions: [23:20] opcode, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] imm.
package cpu_pkg;

  localparam int INSTR_W  = 24;
  localparam int DATA_W   = 8;
  localparam int REG_AW   = 4;
  localparam int PC_W     = 8;
  localparam int OPC_W    = 4;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_ADDI = 4'd5,
    OP_LD   = 4'd6,
    OP_ST   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_JMP  = 4'd9
  } opcode_e;

  // The opcode is kept as raw bits so that illegal encodings 10-15 survive into decode.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // Opcodes whose rs2 field names a real source register.
  function automatic logic reads_rs2(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST, OP_BEQ: reads_rs2 = 1'b1;
      default:                                      reads_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// 16 x 8 register file: two asynchronous read ports, one synchronous write port.
// R0 is hardwired to zero; a same-cycle write is forwarded to matching reads.
module reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == '0)            rd1 = '0;
    else if (we && wa == ra1) rd1 = wd;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == '0)            rd2 = '0;
    else if (we && wa == ra2) rd2 = wd;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID pipeline register, instruction decode, register-file read
// and a one-deep load-use hazard tracker that inserts a single bubble.
module decode_stage
  import cpu_pkg::*;
(
  input  logic               CLK,
  input  logic               reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [PC_W-1:0]    x_pc,
  input  logic               if_valid,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               stall,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_AW-1:0]  rd,
  output logic [DATA_W-1:0]  imm,
  output logic [DATA_W-1:0]  rs1_data,
  output logic [DATA_W-1:0]  rs2_data,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic               jump,
  output logic               illegal
);

  // Handshake: if_valid qualifies Instr/x_pc; id_valid qualifies every decoded
  // output for EX, which always accepts. The only back-pressure is stall, which
  // tells IF to hold its PC and instruction for one cycle.
  logic              id_v;
  instr_t            id_instr;
  logic [PC_W-1:0]   id_pc_q;
  logic              ld_pending;
  logic [REG_AW-1:0] ld_rd;
  logic              ld_hit;

  always_ff @(posedge CLK) begin
    if (reset) begin
      id_v     <= 1'b0;
      id_instr <= '0;
      id_pc_q  <= '0;
    end else if (flush) begin
      id_v <= 1'b0;
    end else if (!stall) begin
      id_v     <= if_valid;
      id_instr <= instr_t'(Instr);
      id_pc_q  <= x_pc;
    end
  end

  // A load issued last cycle whose destination feeds the instruction now in ID.
  always_comb begin
    ld_hit = ld_pending && id_v && (ld_rd != '0) &&
             ((ld_rd == id_instr.rs1) ||
              (reads_rs2(id_instr.opcode) && (ld_rd == id_instr.rs2)));
    stall    = ld_hit && !flush && !reset;
    id_valid = id_v && !stall && !flush && !reset;
  end

  // The bubble issued during a stall is not a load, so the stall self-clears.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ld_pending <= 1'b0;
      ld_rd      <= '0;
    end else begin
      ld_pending <= id_valid && mem_read;
      ld_rd      <= id_instr.rd;
    end
  end

  always_comb begin
    id_pc  = id_pc_q;
    opcode = id_instr.opcode;
    rd     = id_instr.rd;
    imm    = id_instr.imm;
  end

  always_comb begin
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    if (id_valid) begin
      case (id_instr.opcode)
        OP_NOP:                              ;
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_ADDI:                             reg_write = 1'b1;
        OP_LD: begin
          reg_write = 1'b1;
          mem_read  = 1'b1;
        end
        OP_ST:                               mem_write = 1'b1;
        OP_BEQ:                              branch    = 1'b1;
        OP_JMP:                              jump      = 1'b1;
        default:                             illegal   = 1'b1;
      endcase
    end
  end

  reg_file u_reg_file (
    .clk   (CLK),
    .reset (reset),
    .ra1   (id_instr.rs1),
    .ra2   (id_instr.rs2),
    .rd1   (rs1_data),
    .rd2   (rs2_data),
    .we    (wb_en),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations plus a
// cycle-by-cycle comparison against an abstract pipeline model.
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic [23:0] Instr;
  logic [7:0]  x_pc;
  logic        if_valid, flush, wb_en;
  logic [3:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        stall, id_valid;
  logic [7:0]  id_pc, imm, rs1_data, rs2_data;
  logic [3:0]  opcode, rd;
  logic        reg_write, mem_read, mem_write, branch, jump, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage dut (
    .CLK(CLK), .reset(reset), .Instr(Instr), .x_pc(x_pc), .if_valid(if_valid),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .id_valid(id_valid), .id_pc(id_pc), .opcode(opcode), .rd(rd),
    .imm(imm), .rs1_data(rs1_data), .rs2_data(rs2_data), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .illegal(illegal)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- abstract model ----------------
  // Opcode membership sets, one bit per opcode.
  logic [15:0] writes_set = 16'h007E;  // ADD SUB AND OR ADDI LD
  logic [15:0] rs2_set    = 16'h019E;  // ADD SUB AND OR ST BEQ
  logic [7:0]  m_regs [16];
  logic        m_v, m_ldp, model_live;
  logic [23:0] m_instr;
  logic [7:0]  m_pc;
  logic [3:0]  m_ldrd;

  typedef struct {
    logic       stall, idv, rw, mr, mw, br, jp, il;
    logic [7:0] pc, imm, r1, r2;
    logic [3:0] op, rd;
  } exp_t;

  function automatic logic [7:0] mread(input logic [3:0] idx);
    if (idx == 0) return 8'h00;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    logic [3:0] op, rs1, rs2;
    logic hz;
    op  = m_instr[23:20];
    rs1 = m_instr[15:12];
    rs2 = m_instr[11:8];
    hz  = m_ldp && m_v && m_ldrd != 0 && (m_ldrd == rs1 || (rs2_set[op] && m_ldrd == rs2));
    e.stall = hz && !flush && !reset;
    e.idv   = m_v && !e.stall && !flush && !reset;
    e.rw    = e.idv && writes_set[op];
    e.mr    = e.idv && op == 4'd6;
    e.mw    = e.idv && op == 4'd7;
    e.br    = e.idv && op == 4'd8;
    e.jp    = e.idv && op == 4'd9;
    e.il    = e.idv && op >= 4'd10;
    e.pc    = m_pc;
    e.op    = op;
    e.rd    = m_instr[19:16];
    e.imm   = m_instr[7:0];
    e.r1    = mread(rs1);
    e.r2    = mread(rs2);
    return e;
  endfunction

  initial model_live = 1'b0;

  always @(posedge CLK) begin
    exp_t e;
    e = model_eval();
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_v = 0; m_instr = 0; m_pc = 0; m_ldp = 0; m_ldrd = 0;
      model_live = 1'b1;
    end else begin
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      m_ldp  = e.idv && e.op == 4'd6;
      m_ldrd = e.rd;
      if (flush) m_v = 1'b0;
      else if (!e.stall) begin
        m_v = if_valid; m_instr = Instr; m_pc = x_pc;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge CLK) begin
    exp_t e;
    if (model_live) begin
      e = model_eval();
      chk("m.stall", stall, e.stall);
      chk("m.id_valid", id_valid, e.idv);
      chk("m.reg_write", reg_write, e.rw);
      chk("m.mem_read", mem_read, e.mr);
      chk("m.mem_write", mem_write, e.mw);
      chk("m.branch", branch, e.br);
      chk("m.jump", jump, e.jp);
      chk("m.illegal", illegal, e.il);
      chk("m.id_pc", id_pc, e.pc);
      chk("m.opcode", opcode, e.op);
      chk("m.rd", rd, e.rd);
      chk("m.imm", imm, e.imm);
      chk("m.rs1_data", rs1_data, e.r1);
      chk("m.rs2_data", rs2_data, e.r2);
    end
  end

  // ---------------- driver ----------------
  task automatic fetch(input logic [23:0] ins, input logic [7:0] pc);
    Instr = ins; x_pc = pc; if_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1; Instr = '0; x_pc = '0; if_valid = 0; flush = 0;
    wb_en = 0; wb_addr = '0; wb_data = '0;

    // reset state, during and after reset
    cyc();
    chk("rst.id_valid", id_valid, 0);
    chk("rst.stall", stall, 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("post_rst.id_valid", id_valid, 0);
    chk("post_rst.id_pc", id_pc, 0);
    chk("post_rst.reg_write", reg_write, 0);

    // ADD r3,r1,r2 at PC 4
    fetch(24'h131200, 8'h04);
    cyc();
    chk("add.id_valid", id_valid, 1);
    chk("add.opcode", opcode, 1);
    chk("add.rd", rd, 3);
    chk("add.reg_write", reg_write, 1);
    chk("add.id_pc", id_pc, 8'h04);
    chk("add.rs1_data", rs1_data, 0);
    chk("add.rs2_data", rs2_data, 0);

    // write-back bypass into R5, then a write to R0
    fetch(24'h105000, 8'h05);
    cyc();
    wb_en = 1; wb_addr = 4'd5; wb_data = 8'hA7;
    #1;
    chk("bypass.rs1", rs1_data, 8'hA7);
    cyc();
    wb_en = 0;
    #1;
    chk("stored.rs1", rs1_data, 8'hA7);
    fetch(24'h100000, 8'h06);
    wb_en = 1; wb_addr = 4'd0; wb_data = 8'h55;
    cyc();
    chk("r0_bypass.rs1", rs1_data, 0);
    cyc();
    wb_en = 0;
    #1;
    chk("r0_stored.rs1", rs1_data, 0);

    // LD r4 then ADD r6,r4,r1: one bubble, ADD keeps its PC
    fetch(24'h641010, 8'h10);
    cyc();
    chk("ld.mem_read", mem_read, 1);
    fetch(24'h164100, 8'h11);
    cyc();
    chk("lu.stall", stall, 1);
    chk("lu.id_valid", id_valid, 0);
    chk("lu.reg_write", reg_write, 0);
    fetch(24'h000000, 8'h12);
    cyc();
    chk("lu_after.stall", stall, 0);
    chk("lu_after.id_valid", id_valid, 1);
    chk("lu_after.id_pc", id_pc, 8'h11);
    chk("lu_after.rd", rd, 6);

    // LD r4 then ADDI r6,r1 with rs2 field 4: no hazard
    fetch(24'h641010, 8'h20);
    cyc();
    fetch(24'h561403, 8'h21);
    cyc();
    chk("addi.stall", stall, 0);
    chk("addi.id_valid", id_valid, 1);
    chk("addi.imm", imm, 8'h03);

    // branch flush kills a valid SUB
    fetch(24'h212300, 8'h30);
    cyc();
    flush = 1; fetch(24'h131200, 8'h31);
    #1;
    chk("flush.id_valid", id_valid, 0);
    cyc();
    flush = 0;
    #1;
    chk("flush_next.id_valid", id_valid, 0);

    // stall and flush together
    fetch(24'h641010, 8'h40);
    cyc();
    fetch(24'h164100, 8'h41);
    cyc();
    chk("sf.pre_stall", stall, 1);
    flush = 1; fetch(24'h164100, 8'h42);
    #1;
    chk("sf.stall", stall, 0);
    chk("sf.id_valid", id_valid, 0);
    cyc();
    flush = 0;
    #1;
    chk("sf_next.id_valid", id_valid, 0);
    cyc();
    chk("sf_clr.stall", stall, 0);
    chk("sf_clr.id_valid", id_valid, 1);
    chk("sf_clr.id_pc", id_pc, 8'h42);

    // illegal opcode 0xC
    fetch(24'hC12300, 8'h50);
    cyc();
    chk("ill.illegal", illegal, 1);
    chk("ill.reg_write", reg_write, 0);
    chk("ill.mem_read", mem_read, 0);
    chk("ill.mem_write", mem_write, 0);
    chk("ill.branch", branch, 0);
    chk("ill.jump", jump, 0);

    // reset asserted mid-stall
    fetch(24'h641010, 8'h60);
    cyc();
    fetch(24'h164100, 8'h61);
    cyc();
    chk("rs.pre_stall", stall, 1);
    reset = 1;
    #1;
    chk("rs.stall", stall, 0);
    chk("rs.id_valid", id_valid, 0);
    cyc();
    reset = 0;
    #1;
    chk("rs_next.id_valid", id_valid, 0);
    chk("rs_next.stall", stall, 0);
    chk("rs_next.id_pc", id_pc, 0);
    chk("rs_next.opcode", opcode, 0);
    chk("rs_next.rd", rd, 0);
    chk("rs_next.imm", imm, 0);
    chk("rs_next.reg_write", reg_write, 0);
    fetch(24'h105000, 8'h62);
    cyc();
    chk("rs_regs.rs1", rs1_data, 0);

    // mixed traffic checked by the model only
    for (int i = 0; i < 200; i++) begin
      Instr    = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255))};
      x_pc     = 8'(i);
      if_valid = 1'($urandom_range(0, 3) != 0);
      flush    = 1'($urandom_range(0, 7) == 0);
      wb_en    = 1'($urandom_range(0, 1));
      wb_addr  = 4'($urandom_range(0, 7));
      wb_data  = 8'($urandom_range(0, 255));
      cyc();
    end
    flush = 0; wb_en = 0; if_valid = 0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
